// File: rtl/btn_evt_pkg.sv
// Shared constants for the button event controller: index width and the
// layout of the {dir, idx} event code.
package btn_evt_pkg;

   localparam int   IDX_LSB     = 0;
   localparam logic DIR_PRESS   = 1'b1;
   localparam logic DIR_RELEASE = 1'b0;

   // Lane index width; a 2-lane build still needs one index bit.
   function automatic int btn_idw(input int n_btn);
      return (n_btn <= 2) ? 1 : $clog2(n_btn);
   endfunction

   // The direction flag sits directly above the index field.
   function automatic int dir_bit(input int n_btn);
      return btn_idw(n_btn);
   endfunction

endpackage

// File: rtl/btn_debounce_lane.sv
// One button lane: 2-flop synchroniser, tick-paced stability counter and
// debounced level with a one-cycle edge pulse carrying the new direction.
module btn_debounce_lane
   import btn_evt_pkg::*;
#(
   parameter int STABLE_CNT = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic tick,
   input  logic btn_raw,
   output logic level,
   output logic edge_vld,
   output logic edge_dir
);

   localparam int              CNT_W   = (STABLE_CNT < 2) ? 1 : $clog2(STABLE_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);

   logic             sync_p0;
   logic             sync_p1;
   logic             cand;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_p0  <= 1'b0;
         sync_p1  <= 1'b0;
         cand     <= 1'b0;
         cnt      <= '0;
         level    <= 1'b0;
         edge_vld <= 1'b0;
         edge_dir <= DIR_RELEASE;
      end else begin
         // sync_p0 -> sync_p1: metastability guard on the raw pin
         sync_p0  <= btn_raw;
         sync_p1  <= sync_p0;
         edge_vld <= 1'b0;
         if (tick) begin
            if (sync_p1 != cand) begin
               cand <= sync_p1;
               cnt  <= '0;
            end else if (cnt < CNT_MAX) begin
               cnt <= cnt + 1'b1;
               if ((cnt + 1'b1 == CNT_MAX) && (cand != level)) begin
                  level    <= cand;
                  edge_vld <= 1'b1;
                  edge_dir <= cand ? DIR_PRESS : DIR_RELEASE;
               end
            end
         end
      end
   end

endmodule

// File: rtl/btn_event_ctrl.sv
// Debounces N_BTN buttons and queues their press/release transitions in a
// show-ahead FIFO, serialised by a round-robin arbiter over pending lanes.
module btn_event_ctrl
   import btn_evt_pkg::*;
#(
   parameter int  N_BTN      = 4,
   parameter int  TICK_DIV   = 16,
   parameter int  STABLE_CNT = 15,
   parameter int  FIFO_DEPTH = 4,
   localparam int IDW        = btn_idw(N_BTN)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_in,
   output logic [N_BTN-1:0] btn_level,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic [IDW:0]     evt_code,
   output logic             overflow,
   input  logic             clr_ovf
);

   localparam int              DIR_BIT   = dir_bit(N_BTN);
   localparam int              TW        = $clog2(TICK_DIV);
   localparam logic [TW-1:0]   TICK_LAST = TW'(TICK_DIV - 1);
   localparam int              AW        = $clog2(FIFO_DEPTH);
   localparam logic [AW:0]     CNT_FULL  = (AW+1)'(FIFO_DEPTH);

   logic [TW-1:0]    tick_cnt;
   logic             tick;
   logic [N_BTN-1:0] lane_edge;
   logic [N_BTN-1:0] lane_dir;
   logic [N_BTN-1:0] pend, pend_n;
   logic [N_BTN-1:0] pdir, pdir_n;
   logic             ovf_set;
   logic [IDW-1:0]   rr;
   logic [IDW-1:0]   cidx;
   logic [IDW-1:0]   gidx;
   logic             grant;
   logic [IDW:0]     push_word;
   logic [IDW:0]     mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic [AW:0]      count;
   logic             full;
   logic             push, pop;

   assign tick = (tick_cnt == TICK_LAST);

   for (genvar i = 0; i < N_BTN; i++) begin : g_lane
      btn_debounce_lane #(
         .STABLE_CNT (STABLE_CNT)
      ) u_lane (
         .clk      (clk),
         .rst      (rst),
         .tick     (tick),
         .btn_raw  (btn_in[i]),
         .level    (btn_level[i]),
         .edge_vld (lane_edge[i]),
         .edge_dir (lane_dir[i])
      );
   end

   assign full      = (count == CNT_FULL);
   assign evt_valid = (count != '0);
   assign pop       = evt_valid && evt_ready;
   assign push      = grant;
   assign evt_code  = evt_valid ? mem[rd_ptr] : '0;

   // Fullness is judged before this cycle's pop, so a pop never makes room for a same-cycle push.
   always_comb begin
      grant = 1'b0;
      gidx  = '0;
      cidx  = '0;
      if (!full) begin
         for (int k = 1; k <= N_BTN; k++) begin
            cidx = IDW'((int'(rr) + k) % N_BTN);
            if (!grant && pend[cidx]) begin
               grant = 1'b1;
               gidx  = cidx;
            end
         end
      end
   end

   always_comb begin
      pend_n  = pend;
      pdir_n  = pdir;
      ovf_set = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         if (grant && (gidx == IDW'(i)))
            pend_n[i] = 1'b0;
         // A fresh edge on a lane being granted this cycle just re-arms it.
         if (lane_edge[i]) begin
            if (pend[i] && !(grant && (gidx == IDW'(i))))
               ovf_set = 1'b1;
            pend_n[i] = 1'b1;
            pdir_n[i] = lane_dir[i];
         end
      end
   end

   always_comb begin
      push_word                   = '0;
      push_word[DIR_BIT]          = pdir[gidx];
      push_word[IDX_LSB +: IDW]   = gidx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt <= '0;
         pend     <= '0;
         pdir     <= '0;
         rr       <= IDW'(N_BTN - 1);
         overflow <= 1'b0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
      end else begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
         pend     <= pend_n;
         pdir     <= pdir_n;
         if (grant)
            rr <= gidx;
         if (ovf_set)
            overflow <= 1'b1;
         else if (clr_ovf)
            overflow <= 1'b0;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)
            count <= count + 1'b1;
         else if (pop && !push)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_word;
   end

endmodule
